sha_simple_core: RTL and testbench
==================================

Name: sha_simple_core

Overview:
- Iterative SHA-256 compression core, one round per clock.
- Consumes the message as a continuous stream of 32-bit words (16 words per 512-bit block) and maintains the running chaining value across blocks.
- Message padding is done upstream; this core sees already-padded blocks only.
- Used as the minimal hash engine beneath the mining/hashing datapath.

Parameters:
- none (SHA-256 constants fixed: IV H0..H7, K[0..63])

Ports:
- clk   input   1    rising-edge clock
- rst   input   1    asynchronous, active-low reset (0 = reset)
- M     input   32   message word W_t, sampled on rounds 0..15 of each block; ignored on rounds 16..63
- hash  output  256  HashState packed struct {a,b,c,d,e,f,g,h}, 32 bits each, a most significant; current chaining value H0..H7

Behaviour:
- Reset (rst=0, asynchronous):
  - chaining regs H = IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - working vars a..h = IV; round counter t = 0; 16-entry schedule window cleared.
  - hash output = IV.
- Rounds:
  - Every rising clk edge with rst=1 executes exactly one round t.
  - t increments mod 64; there is no start/valid handshake.
  - The first edge after reset release is round 0 of block 0.
- Word schedule:
  - For t<16, W_t = M.
  - For t>=16, W_t = s1(W_{t-2}) + W_{t-7} + s0(W_{t-15}) + W_{t-16}.
  - s0 = ror7^ror18^shr3; s1 = ror17^ror19^shr10.
  - Kept in a 16-word shift window; each round shifts in W_t.
- Round function (all additions mod 2^32):
  - T1 = h + S1(e) + Ch(e,f,g) + K_t + W_t
  - T2 = S0(a) + Maj(a,b,c)
  - S0 = ror2^ror13^ror22; S1 = ror6^ror11^ror25
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c)
  - Update: h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2
- Block completion (edge of round t=63):
  - H_i <= H_i + (round-63 result for var i), for all 8 words.
  - a..h <= that same new H value, so the next block's round 0 runs on the next edge with no bubble cycle.
  - t wraps to 0.
- hash:
  - Registered; changes only on the t=63 edge.
  - Holds the final digest of all blocks fed so far, from that edge until the next block completes.
  - No done flag; the consumer counts 64 cycles per block.
- Reset mid-block: aborts immediately; all state returns to IV and t=0; no partial digest is retained.
- K_t: 64-entry constant ROM (FIPS 180-4), selected combinationally by t.
- Timing: single cycle per round; a full round is on the combinational path (no retiming required).

Test Plan:
- Reset value:
  - Hold rst=0 for 2 cycles -> hash = 6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19.
  - hash stays at IV for the next 63 edges.
- Single block "abc":
  - Stimulus: release reset; W0=61626380, W1..W14=0, W15=00000018, then 48 don't-care edges.
  - After edge 64, hash = ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- Two blocks, 448-bit message:
  - Block 1: W0..W13 = 61626364, 62636465, …, 6e6f7071 (each word +01010101); W14=80000000; W15=0; 48 more edges.
  - Block 2: W0..W14=0, W15=000001c0; 48 more edges.
  - After edge 128, hash = 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1.
  - After edge 64 (block 1 only), hash = the intermediate H.
- M ignored on rounds 16..63:
  - Repeat the "abc" test with random M on rounds 16..63 -> identical digest.
- Mid-block reset:
  - Assert rst=0 during round 30 of the "abc" test -> hash = IV immediately (asynchronous).
  - Restart the full "abc" sequence -> correct abc digest.
- Back-to-back:
  - Feed "abc" block immediately followed by a second padded block with no idle cycle -> digest matches a software SHA-256 chained compression.

Source files
------------

// File: rtl/sha_simple_core.sv
// Iterative SHA-256 compression core: one round per clock, 64 rounds per block,
// free-running round counter with chaining value carried across blocks.
module sha_simple_core (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  M,
  output logic [255:0] hash
);

  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K_ROM [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  logic [31:0] r_h [8];   // chaining value H0..H7
  logic [31:0] r_v [8];   // working variables a..h
  logic [31:0] r_w [16];  // r_w[15] = W_{t-1}, r_w[0] = W_{t-16}
  logic [5:0]  r_t;

  logic [31:0] w_sched, w_wt, w_t1, w_t2, w_ch, w_maj, w_s0, w_s1;
  logic [31:0] w_nv   [8];
  logic [31:0] w_hsum [8];

  always_comb begin
    w_s0    = ror(r_w[1], 7) ^ ror(r_w[1], 18) ^ (r_w[1] >> 3);
    w_s1    = ror(r_w[14], 17) ^ ror(r_w[14], 19) ^ (r_w[14] >> 10);
    w_sched = w_s1 + r_w[9] + w_s0 + r_w[0];
    w_wt    = (r_t < 6'd16) ? M : w_sched;

    w_ch  = (r_v[4] & r_v[5]) ^ (~r_v[4] & r_v[6]);
    w_maj = (r_v[0] & r_v[1]) ^ (r_v[0] & r_v[2]) ^ (r_v[1] & r_v[2]);
    w_t1  = r_v[7] + (ror(r_v[4], 6) ^ ror(r_v[4], 11) ^ ror(r_v[4], 25))
            + w_ch + K_ROM[r_t] + w_wt;
    w_t2  = (ror(r_v[0], 2) ^ ror(r_v[0], 13) ^ ror(r_v[0], 22)) + w_maj;

    w_nv[0] = w_t1 + w_t2;
    w_nv[1] = r_v[0];
    w_nv[2] = r_v[1];
    w_nv[3] = r_v[2];
    w_nv[4] = r_v[3] + w_t1;
    w_nv[5] = r_v[4];
    w_nv[6] = r_v[5];
    w_nv[7] = r_v[6];

    for (int i = 0; i < 8; i++) w_hsum[i] = r_h[i] + w_nv[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        r_h[i] <= IV[i];
        r_v[i] <= IV[i];
      end
      for (int i = 0; i < 16; i++) r_w[i] <= '0;
      r_t <= '0;
    end else begin
      r_t <= r_t + 6'd1;
      for (int i = 0; i < 15; i++) r_w[i] <= r_w[i + 1];
      r_w[15] <= w_wt;
      // Last round folds into H and seeds the next block's round 0 with no bubble
      if (r_t == 6'd63) begin
        for (int i = 0; i < 8; i++) begin
          r_h[i] <= w_hsum[i];
          r_v[i] <= w_hsum[i];
        end
      end else begin
        for (int i = 0; i < 8; i++) r_v[i] <= w_nv[i];
      end
    end
  end

  assign hash = {r_h[0], r_h[1], r_h[2], r_h[3], r_h[4], r_h[5], r_h[6], r_h[7]};

endmodule

// File: tb/tb_sha_simple_core.sv
// Directed bench for sha_simple_core: FIPS 180-4 example digests plus a
// reference compression function for chained back-to-back blocks.
module tb_sha_simple_core;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [31:0]  M   = '0;
  logic [255:0] hash;

  int total = 0;
  int bad   = 0;

  localparam logic [255:0] IV_H   = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_H  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] MID_H  = 256'h85e655d6417a17953363376a624cde5c76e09589cac5f811cc4b32c1f20e533a;
  localparam logic [255:0] TWO_H  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [511:0] abc_blk, two_b1, two_b2, rnd_blk;

  sha_simple_core dut (
    .clk  (clk),
    .rst  (rst),
    .M    (M),
    .hash (hash)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook compression over a full 64-entry schedule array
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] h0 [8];
    logic [31:0] t1, t2;
    logic [255:0] hout;
    for (int i = 0; i < 8; i++) begin
      h0[i] = hin[255 - 32*i -: 32];
      v[i]  = h0[i];
    end
    for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
           + (rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    for (int i = 0; i < 64; i++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[i] + w[i];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
      v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
    end
    for (int i = 0; i < 8; i++) hout[255 - 32*i -: 32] = h0[i] + v[i];
    return hout;
  endfunction

  // Drives one block: M set just after an edge, consumed on the next edge.
  // Returns 1 ns after the completing edge so hash can be sampled there.
  task automatic run_block(input logic [511:0] blk, input bit rand_tail, input bit chk_iv);
    for (int t = 0; t < 64; t++) begin
      if (t < 16)         M = blk[511 - 32*t -: 32];
      else if (rand_tail) M = $urandom;
      else                M = 32'h0;
      @(posedge clk); #1;
      if (chk_iv && t < 63) begin
        total++;
        if (hash !== IV_H) begin
          bad++;
          $display("FAIL iv_hold edge %0d: got %h exp %h", t + 1, hash, IV_H);
        end
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    M   = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (hash !== IV_H) begin
      bad++;
      $display("FAIL reset_iv: got %h exp %h", hash, IV_H);
    end
  endtask

  task automatic test_abc();
    rst = 1'b1;
    run_block(abc_blk, 1'b0, 1'b1);
    total++;
    if (hash !== ABC_H) begin
      bad++;
      $display("FAIL abc_digest: got %h exp %h", hash, ABC_H);
    end
  endtask

  task automatic test_two_block();
    apply_reset();
    run_block(two_b1, 1'b0, 1'b0);
    total++;
    if (hash !== MID_H) begin
      bad++;
      $display("FAIL two_mid: got %h exp %h", hash, MID_H);
    end
    run_block(two_b2, 1'b0, 1'b0);
    total++;
    if (hash !== TWO_H) begin
      bad++;
      $display("FAIL two_final: got %h exp %h", hash, TWO_H);
    end
  endtask

  task automatic test_ignore_m();
    apply_reset();
    run_block(abc_blk, 1'b1, 1'b0);
    total++;
    if (hash !== ABC_H) begin
      bad++;
      $display("FAIL ignore_m: got %h exp %h", hash, ABC_H);
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    run_block(abc_blk, 1'b0, 1'b0);
    total++;
    if (hash !== ABC_H) begin
      bad++;
      $display("FAIL midrst_pre: got %h exp %h", hash, ABC_H);
    end
    for (int t = 0; t < 30; t++) begin
      M = (t < 16) ? abc_blk[511 - 32*t -: 32] : 32'h0;
      @(posedge clk); #1;
    end
    M   = 32'hdeadbeef;
    rst = 1'b0;
    #1;
    total++;
    if (hash !== IV_H) begin
      bad++;
      $display("FAIL midrst_async: got %h exp %h", hash, IV_H);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    run_block(abc_blk, 1'b0, 1'b0);
    total++;
    if (hash !== ABC_H) begin
      bad++;
      $display("FAIL midrst_restart: got %h exp %h", hash, ABC_H);
    end
  endtask

  task automatic test_back_to_back();
    logic [255:0] exp_h;
    for (int i = 0; i < 16; i++) rnd_blk[511 - 32*i -: 32] = $urandom;
    apply_reset();
    run_block(abc_blk, 1'b0, 1'b0);
    total++;
    if (hash !== ABC_H) begin
      bad++;
      $display("FAIL b2b_first: got %h exp %h", hash, ABC_H);
    end
    exp_h = compress(ABC_H, rnd_blk);
    run_block(rnd_blk, 1'b1, 1'b0);
    total++;
    if (hash !== exp_h) begin
      bad++;
      $display("FAIL b2b_second: got %h exp %h", hash, exp_h);
    end
    exp_h = compress(exp_h, two_b2);
    run_block(two_b2, 1'b0, 1'b0);
    total++;
    if (hash !== exp_h) begin
      bad++;
      $display("FAIL b2b_third: got %h exp %h", hash, exp_h);
    end
  endtask

  initial begin
    abc_blk = {32'h61626380, 448'h0, 32'h00000018};
    two_b1  = '0;
    for (int i = 0; i < 14; i++) two_b1[511 - 32*i -: 32] = 32'h61626364 + 32'h01010101 * i;
    two_b1[511 - 32*14 -: 32] = 32'h80000000;
    two_b2  = {480'h0, 32'h000001c0};
    rnd_blk = '0;

    test_reset();
    test_abc();
    test_two_block();
    test_ignore_m();
    test_mid_reset();
    test_back_to_back();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
